vga_text_fetch_arbiter: RTL and testbench

//  Shares the single-port synchronous text RAM (32x16 cells, 8-bit codes) between the display
//  and the CPU peripheral port. Fixed display fetch slot in every 32-clock character cell;
//  all other cycles go to the CPU. Fetch is driven by the VGA timing counters and returns one

---
 rtl/vga_text_fetch_arbiter_if.sv | 29 ++
 rtl/vga_text_fetch_arbiter.sv | 140 ++++++++++++++
 tb/tb_vga_text_fetch_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_fetch_arbiter_if.sv
// CPU peripheral port and single-port text RAM port of the text fetch arbiter.
interface vga_text_fetch_arbiter_if;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  // CPU and RAM side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  cpu_ack, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vga_text_fetch_arbiter.sv
// Shares the single-port text RAM between the display character fetch (fixed
// slot per 32-clock cell, always wins) and a req/ack CPU port.
module vga_text_fetch_arbiter #(
  parameter int unsigned COLS       = 32,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned LAST_XHI   = 41,
  parameter int unsigned FETCH_SLOT = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [5:0]                     x_hi,
  input  logic [4:0]                     x_lo,
  input  logic [4:0]                     y_hi,
  vga_text_fetch_arbiter_if.slave        bus,
  output logic [7:0]                     char_code,
  output logic                           char_valid
);
  localparam int unsigned AW       = 9;
  localparam int unsigned DW       = 8;
  localparam int unsigned XLO_LAST = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          rd_pend_q, rd_pend_d;
  logic          disp_slot_q, disp_slot_d;
  logic [DW-1:0] char_next_q, char_next_d;
  logic          fetched_q, fetched_d;
  logic [DW-1:0] char_code_q, char_code_d;
  logic          char_valid_q, char_valid_d;

  logic          disp_slot_c;
  logic [AW-1:0] fetch_addr_c;
  logic          cpu_issue_c;

  // Display slot decode; the x_hi==LAST_XHI slot prefetches column 0 of the line y_hi already names
  always_comb begin
    disp_slot_c  = (x_lo == 5'(FETCH_SLOT)) && (y_hi < 5'(ROWS)) &&
                   ((x_hi < 6'(COLS - 1)) || (x_hi == 6'(LAST_XHI)));
    fetch_addr_c = (x_hi == 6'(LAST_XHI)) ? {y_hi[3:0], 5'd0}
                                          : {y_hi[3:0], x_hi[4:0] + 5'd1};
    cpu_issue_c  = (state_q == ST_ISSUE) && !disp_slot_c;
  end

  // RAM port mux, forced idle while reset is asserted
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (rst_n) begin
      if (disp_slot_c) begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = fetch_addr_c;
      end else if (cpu_issue_c) begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = bus.cpu_we;
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
      end
    end
  end

  // Next-state for the CPU FSM and the display character pipeline
  always_comb begin
    state_d      = state_q;
    cpu_rdata_d  = cpu_rdata_q;
    rd_pend_d    = rd_pend_q;
    disp_slot_d  = disp_slot_c;
    char_next_d  = char_next_q;
    fetched_d    = fetched_q;
    char_code_d  = char_code_q;
    char_valid_d = char_valid_q;

    unique case (state_q)
      ST_IDLE:  if (bus.cpu_req) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (!disp_slot_c) begin
          rd_pend_d = !bus.cpu_we;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_pend_q) cpu_rdata_d = bus.ram_rdata;
        state_d = ST_ACK;
      end
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    cpu_ack_d = (state_d == ST_ACK);

    // Capture only real fetch data so that char_code holds across fetch-less columns
    if (x_lo == 5'(FETCH_SLOT + 1)) begin
      fetched_d = disp_slot_q;
      if (disp_slot_q) char_next_d = bus.ram_rdata;
    end
    if (x_lo == 5'(XLO_LAST)) begin
      char_code_d  = char_next_q;
      char_valid_d = fetched_q;
      fetched_d    = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      rd_pend_q    <= 1'b0;
      disp_slot_q  <= 1'b0;
      char_next_q  <= '0;
      fetched_q    <= 1'b0;
      char_code_q  <= '0;
      char_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      rd_pend_q    <= rd_pend_d;
      disp_slot_q  <= disp_slot_d;
      char_next_q  <= char_next_d;
      fetched_q    <= fetched_d;
      char_code_q  <= char_code_d;
      char_valid_q <= char_valid_d;
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign char_code     = char_code_q;
  assign char_valid    = char_valid_q;
endmodule

// File: tb/tb_vga_text_fetch_arbiter.sv
// Bench for vga_text_fetch_arbiter: free-running timing, RAM model, directed
// scenarios plus random CPU traffic against a latency/snapshot reference model.
module tb_vga_text_fetch_arbiter;
  localparam int unsigned FS = 8;

  typedef struct packed {
    logic       we;
    logic [8:0] addr;
    logic [7:0] wd;
  } req_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] tx_hi;
  logic [4:0] tx_lo;
  logic [4:0] ty;
  logic [7:0] char_code;
  logic       char_valid;
  logic       ram_load;

  vga_text_fetch_arbiter_if bus ();

  vga_text_fetch_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_hi      (tx_hi),
    .x_lo      (tx_lo),
    .y_hi      (ty),
    .bus       (bus),
    .char_code (char_code),
    .char_valid(char_valid)
  );

  always #5 clk = ~clk;

  // Synchronous single-port text RAM, preloaded with RAM[a] = a[7:0]
  logic [7:0] mem [512];
  logic [7:0] rdata_r;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int a = 0; a < 512; a++) mem[a] <= 8'(a);
      rdata_r <= 8'h00;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            rdata_r <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = rdata_r;

  int errors = 0;
  int checks = 0;
  int n      = 0;
  int frame  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Stimulus-side CPU driver state
  req_t q[$];
  bit   req_on, ack_seen, rand_mode, rst_pending;
  int   rst_at = -1000, t3 = -1000, t6 = -1000;
  int   t6_cnt = 0, t6_last = -1, rst_cnt = 0;

  // Reference model state
  logic [7:0] ref_mem [512];
  bit         m_have, m_issued;
  int         m_issue_from, m_ack_at, m_free_from;
  logic       m_we;
  logic [8:0] m_addr;
  logic [7:0] m_wd, m_rd, m_last_rd;
  bit         d_fetched, d_known;
  logic [7:0] d_snap, d_code;

  task automatic model_reset();
    m_have = 0; m_issued = 0; m_free_from = n;
    m_last_rd = 8'h00;
    d_fetched = 0; d_known = 1; d_code = 8'h00; d_snap = 8'h00;
  endtask

  task automatic advance();
    if (tx_lo == 5'd31) begin
      tx_lo = 5'd0;
      tx_hi = (tx_hi == 6'd41) ? 6'd0 : tx_hi + 6'd1;
      if (tx_hi == 6'd36) begin
        if (ty == 5'd17) begin ty = 5'd0; frame++; end
        else ty = ty + 5'd1;
      end
    end else begin
      tx_lo = tx_lo + 5'd1;
    end
  endtask

  task automatic push(input logic we, input logic [8:0] addr, input logic [7:0] wd);
    req_t r;
    r.we = we; r.addr = addr; r.wd = wd;
    q.push_back(r);
  endtask

  // Start of cycle: directed injections, random traffic, req/ack handshake
  task automatic drive_cpu();
    req_t r;
    if (frame == 0 && ty == 0 && tx_hi == 0 && tx_lo == 5'd7) push(1'b0, 9'h123, 8'h00);
    if (frame == 0 && ty == 16 && tx_hi == 2 && tx_lo == 0) begin
      t3 = n;
      push(1'b1, 9'h1FF, 8'hA5);
      push(1'b0, 9'h1FF, 8'h00);
    end
    if (frame == 0 && ty == 17 && tx_hi == 2 && tx_lo == 0) begin
      t6 = n;
      for (int i = 0; i < 5; i++) push(1'b0, (i % 2 == 0) ? 9'h0AA : 9'h155, 8'h00);
    end
    if (frame == 1 && ty == 0 && tx_hi == 36 && tx_lo == 0) rand_mode = 1;
    if (frame == 1 && ty == 16 && tx_hi == 0 && tx_lo == 0) rand_mode = 0;
    if (frame == 1 && ty == 16 && tx_hi == 4 && tx_lo == 0) begin
      push(1'b0, 9'h055, 8'h00);
      rst_pending = 1;
    end
    if (n == rst_at + 14) push(1'b0, 9'h0AB, 8'h00);

    if (req_on && ack_seen) req_on = 0;
    ack_seen = 0;
    if (!req_on && q.size() == 0 && rand_mode && $urandom_range(0, 2) == 0)
      push(1'($urandom_range(0, 1)), 9'($urandom), 8'($urandom));
    if (!req_on && q.size() > 0) begin
      r = q.pop_front();
      req_on = 1;
      bus.cpu_we    = r.we;
      bus.cpu_addr  = r.addr;
      bus.cpu_wdata = r.wd;
      if (rst_pending) begin rst_at = n + 2; rst_pending = 0; end
    end
    bus.cpu_req = req_on;
  endtask

  // Reference model: display snapshot per slot, CPU access in first free non-slot cycle
  task automatic model_check();
    logic       slot, e_en, e_we, e_ack;
    logic [8:0] faddr, e_addr;
    logic [7:0] e_wd;
    slot  = (tx_lo == 5'(FS)) && (ty < 5'd16) && ((tx_hi < 6'd31) || (tx_hi == 6'd41));
    faddr = (tx_hi == 6'd41) ? {ty[3:0], 5'd0} : {ty[3:0], tx_hi[4:0] + 5'd1};

    if (tx_lo == 5'd0) begin
      chk("char_valid", 32'(char_valid), 32'(d_fetched));
      if (d_fetched) begin d_code = d_snap; d_known = 1; end
      if (d_known) chk("char_code", 32'(char_code), 32'(d_code));
      d_fetched = 0;
    end

    e_en = 0; e_we = 0; e_addr = 9'h000; e_wd = 8'h00;
    if (slot) begin
      e_en = 1; e_addr = faddr;
      d_snap = ref_mem[faddr]; d_fetched = 1;
    end else if (m_have && !m_issued && n >= m_issue_from) begin
      e_en = 1; e_we = m_we; e_addr = m_addr; e_wd = m_wd;
      m_issued = 1; m_ack_at = n + 2;
      if (m_we) ref_mem[m_addr] = m_wd;
      else      m_rd = ref_mem[m_addr];
    end
    chk("ram_en", 32'(bus.ram_en), 32'(e_en));
    chk("ram_we", 32'(bus.ram_we), 32'(e_we));
    if (e_en) chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
    if (e_we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wd));

    e_ack = m_have && m_issued && (n == m_ack_at);
    chk("cpu_ack", 32'(bus.cpu_ack), 32'(e_ack));
    if (e_ack) begin
      if (!m_we) m_last_rd = m_rd;
      chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_last_rd));
      m_have = 0; m_free_from = n + 1;
    end
    if (!m_have && n >= m_free_from && bus.cpu_req) begin
      m_have = 1; m_issued = 0; m_issue_from = n + 1;
      m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wd = bus.cpu_wdata;
    end
  endtask

  // Directed checks at fixed raster positions and scenario offsets
  task automatic directed();
    if (frame == 0 && ty == 0 && tx_hi == 0) begin
      if (tx_lo == 5'd8) begin
        chk("t4_disp_addr", 32'(bus.ram_addr), 32'h001);
        chk("t4_disp_we", 32'(bus.ram_we), 32'd0);
      end
      if (tx_lo == 5'd9) begin
        chk("t4_cpu_en", 32'(bus.ram_en), 32'd1);
        chk("t4_cpu_addr", 32'(bus.ram_addr), 32'h123);
      end
      if (tx_lo == 5'd10) chk("t4_early_ack", 32'(bus.cpu_ack), 32'd0);
      if (tx_lo == 5'd11) begin
        chk("t4_ack", 32'(bus.cpu_ack), 32'd1);
        chk("t4_rdata", 32'(bus.cpu_rdata), 32'h23);
      end
    end
    if (frame == 0 && ty == 0 && tx_hi == 1 && tx_lo == 0) begin
      chk("t4_char", 32'(char_code), 32'h01);
      chk("t4_valid", 32'(char_valid), 32'd1);
    end
    if (frame == 0 && ty == 2 && tx_hi == 4 && tx_lo == 5'd8) begin
      chk("t1_en", 32'(bus.ram_en), 32'd1);
      chk("t1_addr", 32'(bus.ram_addr), 32'h045);
    end
    if (frame == 0 && ty == 2 && tx_hi == 5 && tx_lo == 0) begin
      chk("t1_char", 32'(char_code), 32'h45);
      chk("t1_valid", 32'(char_valid), 32'd1);
    end
    if (frame == 0 && tx_lo == 0 &&
        ((ty == 2 && tx_hi >= 32 && tx_hi < 36) || (ty == 3 && tx_hi >= 36)))
      chk("t1_blank", 32'(char_valid), 32'd0);
    if (frame == 0 && ty == 3 && tx_hi == 41 && tx_lo == 5'd8) begin
      chk("t2_en", 32'(bus.ram_en), 32'd1);
      chk("t2_addr", 32'(bus.ram_addr), 32'h060);
    end
    if (frame == 0 && ty == 3 && tx_hi == 0 && tx_lo == 0) begin
      chk("t2_char", 32'(char_code), 32'h60);
      chk("t2_valid", 32'(char_valid), 32'd1);
    end
    if (n == t3 + 1) begin
      chk("t3_ram_we", 32'(bus.ram_we), 32'd1);
      chk("t3_ram_addr", 32'(bus.ram_addr), 32'h1FF);
    end
    if (n == t3 + 3) chk("t3_wr_ack", 32'(bus.cpu_ack), 32'd1);
    if (n == t3 + 7) begin
      chk("t3_rd_ack", 32'(bus.cpu_ack), 32'd1);
      chk("t3_rdata", 32'(bus.cpu_rdata), 32'hA5);
    end
    if (n >= t6 && n < t6 + 25 && bus.cpu_ack) begin
      if (t6_last >= 0) chk("t6_gap", 32'(n - t6_last), 32'd4);
      t6_last = n;
      t6_cnt++;
    end
    if (n == t6 + 25) chk("t6_acks", 32'(t6_cnt), 32'd5);
    if (n > rst_at && n <= rst_at + 13 && bus.cpu_ack) rst_cnt++;
    if (n == rst_at + 13) chk("rst_noack", 32'(rst_cnt), 32'd0);
  endtask

  initial begin
    bit skip, finished, rst_hit;
    finished = 0; rst_hit = 0;
    for (int a = 0; a < 512; a++) ref_mem[a] = 8'(a);
    rst_n = 1'b0; ram_load = 1'b1;
    tx_hi = 6'd0; tx_lo = 5'd0; ty = 5'd0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h000; bus.cpu_wdata = 8'h00;
    req_on = 0; ack_seen = 0; rand_mode = 0; rst_pending = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(bus.cpu_ack), 32'd0);
    chk("reset_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("reset_char", 32'(char_code), 32'd0);
    chk("reset_valid", 32'(char_valid), 32'd0);
    chk("reset_ram_en", 32'(bus.ram_en), 32'd0);
    rst_n = 1'b1; ram_load = 1'b0;

    while (n < 60000 && !finished) begin
      drive_cpu();
      skip = 0;
      if (n == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(bus.cpu_ack), 32'd0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_char", 32'(char_code), 32'd0);
        chk("rst_valid", 32'(char_valid), 32'd0);
        chk("rst_ram_en", 32'(bus.ram_en), 32'd0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        req_on = 0; bus.cpu_req = 1'b0; q.delete();
        model_reset();
        skip = 1; rst_hit = 1;
      end
      @(negedge clk);
      if (!skip) begin
        model_check();
        directed();
      end
      ack_seen = bus.cpu_ack;
      if (rst_hit && n == rst_at + 30) finished = 1;
      @(posedge clk);
      #1;
      n++;
      advance();
      if (!rst_n) rst_n = 1'b1;
    end
    chk("run_complete", 32'(finished), 32'd1);
    chk("reset_scenario_hit", 32'(rst_hit), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
